// File: rtl/sseg_scan_hex_encoder.sv
// Loop-back reader for a multiplexed active-low seven-segment bus: debounces each
// digit dwell, decodes glyphs, assembles frames and hands them out on Valid/Ack.
module sseg_scan_hex_encoder #(
    parameter int DIGITS        = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [DIGITS-1:0]     An,
    input  logic [7:0]            SSeg,
    input  logic                  Ack,
    output logic [4*DIGITS-1:0]   Value,
    output logic [DIGITS-1:0]     DPMask,
    output logic [DIGITS-1:0]     BlankMask,
    output logic                  Valid,
    output logic                  Error,
    output logic                  Overrun
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic {IDLE, COLLECT} state_t;

    // {bad, blank, nibble}
    function automatic logic [5:0] decode(input logic [6:0] s);
        logic [5:0] r;
        case (s)
            7'b0000001: r = 6'h00;
            7'b1001111: r = 6'h01;
            7'b0010010: r = 6'h02;
            7'b0000110: r = 6'h03;
            7'b1001100: r = 6'h04;
            7'b0100100: r = 6'h05;
            7'b0100000: r = 6'h06;
            7'b0001111: r = 6'h07;
            7'b0000000: r = 6'h08;
            7'b0000100: r = 6'h09;
            7'b0001000: r = 6'h0A;
            7'b1100000: r = 6'h0B;
            7'b0110001: r = 6'h0C;
            7'b1000010: r = 6'h0D;
            7'b0110000: r = 6'h0E;
            7'b0111000: r = 6'h0F;
            7'b1111111: r = 6'b010000;
            default:    r = 6'b100000;
        endcase
        return r;
    endfunction

    logic [DIGITS-1:0]   an_r;
    logic [7:0]          sseg_r;
    logic [DIGITS+7:0]   prev_key;
    logic [7:0]          cnt;
    logic                cap_vld;
    logic [DIGITS-1:0]   cap_an;
    logic [7:0]          cap_seg;

    state_t              state;
    logic [IW-1:0]       idx;
    logic [4*DIGITS-1:0] w_val;
    logic [DIGITS-1:0]   w_dp;
    logic [DIGITS-1:0]   w_blank;
    logic                w_fault;

    logic [DIGITS+7:0]   key;
    logic                same;
    logic [DIGITS-1:0]   lo;
    logic                onehot;
    logic                all_high;
    logic [IW-1:0]       dig;
    logic                g_bad;
    logic                g_blank;
    logic [3:0]          g_nib;
    logic                g_dp;
    logic [4*DIGITS-1:0] frm_val;
    logic [DIGITS-1:0]   frm_dp;
    logic [DIGITS-1:0]   frm_blank;
    logic                frm_fault;
    logic                hit;
    logic                in_order;
    logic                done;

    always_comb begin
        key      = {an_r, sseg_r};
        same     = (key == prev_key);
        lo       = ~cap_an;
        onehot   = (lo != '0) && ((lo & (lo - 1'b1)) == '0);
        all_high = &cap_an;
        dig      = '0;
        for (int k = 0; k < DIGITS; k++)
            if (lo[k]) dig = IW'(k);
        {g_bad, g_blank, g_nib} = decode(cap_seg[7:1]);
        g_dp      = ~cap_seg[0];
        frm_val   = w_val;
        frm_val[4*int'(dig) +: 4] = g_nib;
        frm_dp    = w_dp;
        frm_dp[dig]    = g_dp;
        frm_blank = w_blank;
        frm_blank[dig] = g_blank;
        frm_fault = w_fault | g_bad;
        hit       = cap_vld && onehot;
        in_order  = hit && (state == COLLECT) && (dig == idx) && (dig != '0);
        done      = in_order && (idx == IW'(DIGITS-1));
    end

    // Input sampling and dwell debounce; capture is a registered one-shot
    // carrying the sample that completed the stable run.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            an_r     <= '1;
            sseg_r   <= '1;
            prev_key <= '1;
            cnt      <= '0;
            cap_vld  <= 1'b0;
            cap_an   <= '1;
            cap_seg  <= '1;
        end else begin
            an_r     <= An;
            sseg_r   <= SSeg;
            prev_key <= key;
            cap_vld  <= 1'b0;
            if (!same)
                cnt <= 8'd1;
            else if (cnt != 8'(STABLE_CYCLES)) begin
                cnt <= cnt + 8'd1;
                if (cnt == 8'(STABLE_CYCLES-1)) begin
                    cap_vld <= 1'b1;
                    cap_an  <= an_r;
                    cap_seg <= sseg_r;
                end
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            w_val     <= '0;
            w_dp      <= '0;
            w_blank   <= '0;
            w_fault   <= 1'b0;
            Value     <= '0;
            DPMask    <= '0;
            BlankMask <= '0;
            Valid     <= 1'b0;
            Error     <= 1'b0;
            Overrun   <= 1'b0;
        end else begin
            Overrun <= 1'b0;
            if (cap_vld) begin
                if (!onehot) begin
                    if (!all_high && state == COLLECT)
                        w_fault <= 1'b1;
                end else if (dig == '0) begin
                    w_val   <= frm_val;
                    w_dp    <= frm_dp;
                    w_blank <= frm_blank;
                    w_fault <= g_bad;
                    idx     <= IW'(1);
                    state   <= COLLECT;
                end else if (in_order) begin
                    w_val   <= frm_val;
                    w_dp    <= frm_dp;
                    w_blank <= frm_blank;
                    w_fault <= frm_fault;
                    idx     <= idx + 1'b1;
                    if (done)
                        state <= IDLE;
                end else if (state == COLLECT) begin
                    state <= IDLE;
                end
            end

            if (done) begin
                if (!Valid || Ack) begin
                    Value     <= frm_val;
                    DPMask    <= frm_dp;
                    BlankMask <= frm_blank;
                    Error     <= frm_fault;
                    Valid     <= 1'b1;
                end else begin
                    Overrun <= 1'b1;
                end
            end else if (Valid && Ack) begin
                Valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sseg_scan_hex_encoder.sv
// Directed bench for sseg_scan_hex_encoder (DIGITS=4, STABLE_CYCLES=4).
module tb_sseg_scan_hex_encoder;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [3:0]  An = 4'hF;
    logic [7:0]  SSeg = 8'hFF;
    logic        Ack = 1'b0;
    logic [15:0] Value;
    logic [3:0]  DPMask;
    logic [3:0]  BlankMask;
    logic        Valid;
    logic        Error;
    logic        Overrun;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;

    sseg_scan_hex_encoder #(.DIGITS(4), .STABLE_CYCLES(4)) dut (
        .Clk(Clk), .Reset(Reset), .An(An), .SSeg(SSeg), .Ack(Ack),
        .Value(Value), .DPMask(DPMask), .BlankMask(BlankMask),
        .Valid(Valid), .Error(Error), .Overrun(Overrun)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;
            4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;
            4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;
            4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;
            4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;
            4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;
            4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;
            default: return 7'b0111000;
        endcase
    endfunction

    task automatic show_raw(input logic [3:0] an, input logic [7:0] seg, input int n);
        An = an;
        SSeg = seg;
        repeat (n) begin
            @(negedge Clk);
            ovr_cnt += int'(Overrun);
        end
    endtask

    task automatic show(input int d, input logic [3:0] nib, input int n);
        logic [3:0] an;
        an = 4'hF;
        an[d] = 1'b0;
        show_raw(an, {glyph(nib), 1'b1}, n);
    endtask

    task automatic idle(input int n);
        show_raw(4'hF, 8'hFF, n);
    endtask

    task automatic scan(input logic [15:0] v);
        for (int d = 0; d < 4; d++) show(d, v[4*d +: 4], 8);
        idle(2);
    endtask

    task automatic ack_pulse();
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        chk("rst_value", 32'(Value), 32'h0);
        chk("rst_valid", 32'(Valid), 32'h0);
        chk("rst_flags", {29'h0, Error, Overrun, |DPMask | |BlankMask}, 32'h0);
        Reset = 1'b0;
        idle(6);

        // Frame 1 with latency check on the last digit
        show(0, 4'h1, 8); show(1, 4'h2, 8); show(2, 4'hA, 8);
        show(3, 4'hF, 5);
        chk("lat_before", 32'(Valid), 32'h0);
        show(3, 4'hF, 1);
        chk("lat_at", 32'(Valid), 32'h1);
        show(3, 4'hF, 2);
        idle(2);
        chk("f1_value", 32'(Value), 32'hFA21);
        chk("f1_dp", 32'(DPMask), 32'h0);
        chk("f1_blank", 32'(BlankMask), 32'h0);
        chk("f1_err", 32'(Error), 32'h0);
        chk("f1_hold", 32'(Valid), 32'h1);
        ack_pulse();
        chk("f1_ack", 32'(Valid), 32'h0);
        chk("f1_keep", 32'(Value), 32'hFA21);

        // DP, blank and unrecognised glyph
        show(0, 4'h1, 8);
        show_raw(4'b1101, 8'b11111101, 8);
        show_raw(4'b1011, {glyph(4'hA), 1'b0}, 8);
        show_raw(4'b0111, 8'hFF, 8);
        idle(2);
        chk("f2_value", 32'(Value), 32'h0A01);
        chk("f2_dp", 32'(DPMask), 32'h4);
        chk("f2_blank", 32'(BlankMask), 32'h8);
        chk("f2_err", 32'(Error), 32'h1);
        ack_pulse();

        // Short dwell on digit 1
        show(0, 4'h0, 8); show(1, 4'h0, 3); show(2, 4'h0, 8); show(3, 4'h0, 8);
        idle(2);
        chk("short_novalid", 32'(Valid), 32'h0);
        scan(16'h6543);
        chk("f3_value", 32'(Value), 32'h6543);
        chk("f3_err", 32'(Error), 32'h0);
        ack_pulse();

        // Out-of-order then full scan
        show(0, 4'h1, 8); show(2, 4'h3, 8); idle(2);
        chk("ooo_novalid", 32'(Valid), 32'h0);
        scan(16'h0987);
        chk("f4_value", 32'(Value), 32'h0987);
        chk("f4_err", 32'(Error), 32'h0);
        ack_pulse();

        // Anode overlap inside a frame
        show(0, 4'h1, 8); show(1, 4'h2, 8);
        show_raw(4'b1100, {glyph(4'h8), 1'b1}, 6);
        show(2, 4'h3, 8); show(3, 4'h4, 8); idle(2);
        chk("ovl_value", 32'(Value), 32'h4321);
        chk("ovl_err", 32'(Error), 32'h1);
        ack_pulse();

        // Overrun on unacknowledged frame
        scan(16'h4321);
        chk("o1_valid", 32'(Valid), 32'h1);
        ovr_cnt = 0;
        scan(16'h8765);
        chk("ovr_pulse", 32'(ovr_cnt), 32'h1);
        chk("ovr_value", 32'(Value), 32'h4321);
        chk("ovr_valid", 32'(Valid), 32'h1);
        // Ack coincident with completion of a third frame
        ovr_cnt = 0;
        show(0, 4'hF, 8); show(1, 4'hE, 8); show(2, 4'hD, 8);
        show(3, 4'hC, 5);
        Ack = 1'b1;
        show(3, 4'hC, 1);
        Ack = 1'b0;
        show(3, 4'hC, 2);
        idle(2);
        chk("coin_value", 32'(Value), 32'hCDEF);
        chk("coin_valid", 32'(Valid), 32'h1);
        chk("coin_noovr", 32'(ovr_cnt), 32'h0);

        // Reset mid-frame while Valid=1
        show(0, 4'h1, 8); show(1, 4'h3, 8); show(2, 4'h5, 4);
        Reset = 1'b1;
        show(2, 4'h5, 1);
        Reset = 1'b0;
        chk("mrst_value", 32'(Value), 32'h0);
        chk("mrst_valid", 32'(Valid), 32'h0);
        chk("mrst_flags", {28'h0, Error, Overrun, |DPMask, |BlankMask}, 32'h0);
        show(2, 4'h5, 4); show(3, 4'h7, 8); idle(2);
        chk("mrst_noframe", 32'(Valid), 32'h0);
        scan(16'h7531);
        chk("post_value", 32'(Value), 32'h7531);
        chk("post_valid", 32'(Valid), 32'h1);
        chk("post_err", 32'(Error), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sseg_scan_hex_encoder.md
Name: sseg_scan_hex_encoder

Overview:
- Reads back a multiplexed, active-low seven-segment display bus (digit anodes plus segments/DP) and recovers the displayed hex word and decimal-point mask.
- Used as the loop-back checker and readout for display-driving logic.
- Each digit is debounced per dwell, validated against the canonical glyph table, and assembled into a frame.
- Completed frames are presented on a Valid/Ack handshake.

Parameters:
DIGITS, 4, number of multiplexed digits (2..8)
STABLE_CYCLES, 4, consecutive identical samples required before a digit is captured (2..255)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high reset
An  input  DIGITS  digit enables, active-low; An[0] = least-significant digit
SSeg  input  8  segments, active-low; [7:1]=a,b,c,d,e,f,g, [0]=DP
Ack  input  1  consumer accepts current frame
Value  output  4*DIGITS  decoded hex; digit k at [4k+3:4k]
DPMask  output  DIGITS  1 = DP lit on digit k
BlankMask  output  DIGITS  1 = digit k was all segments off
Valid  output  1  frame available; held until accepted
Error  output  1  frame contained an unrecognised glyph or an anode fault
Overrun  output  1  one-cycle pulse: completed frame dropped

Behaviour:
- Reset: Value=0, DPMask=0, BlankMask=0, Valid=0, Error=0, Overrun=0; input registers=all-ones; stability counter=0; FSM=IDLE.
- Inputs are registered once, giving sampled An_r and SSeg_r.
- Stability counter:
  - Reloads to 1 when {An_r,SSeg_r} differs from its previous value.
  - Otherwise increments, saturating at STABLE_CYCLES.
  - A capture fires exactly once per dwell, on the cycle the counter reaches STABLE_CYCLES, and only if An_r is exactly one-hot-low.
- Anode fault: An_r all-high produces no capture. More than one bit low produces no capture and sets the frame fault flag if the FSM is in COLLECT.
- Glyph table, SSeg[7:1] -> nibble:
  - 0000001=0, 1001111=1, 0010010=2, 0000110=3, 1001100=4, 0100100=5, 0100000=6, 0001111=7
  - 0000000=8, 0000100=9, 0001000=A, 1100000=b, 0110001=C, 1000010=d, 0110000=E, 0111000=F
  - 1111111 = blank: nibble 0, blank bit set.
  - Any other pattern: nibble 0, frame fault set.
  - DP bit = ~SSeg_r[0].
- FSM IDLE: a capture on digit 0 stores digit 0 into working registers, clears the fault flag, sets expected index=1 and goes to COLLECT. Captures on other digits are ignored.
- FSM COLLECT:
  - Capture on the expected index: store it and increment the index.
  - Capture on digit 0: restart the frame, same as the IDLE action.
  - Capture on any other index: discard the working frame and go to IDLE.
  - Capture of digit DIGITS-1 in order completes the frame and returns to IDLE, ready for the next scan.
- Frame completion is registered:
  - If Valid=0, or Valid=1 with Ack=1 in the same cycle: load Value/DPMask/BlankMask/Error from the working registers and set Valid=1 on the next cycle.
  - If Valid=1 and Ack=0: outputs are unchanged and Overrun pulses for one cycle.
- Ack with Valid=1 and no simultaneous completion: Valid=0 next cycle. Outputs hold their last values. Ack with Valid=0 is ignored.
- Latency: Valid rises on the (STABLE_CYCLES+2)th rising edge after the last digit's An/SSeg are applied and held: 1 input register, STABLE_CYCLES counts, 1 output register.
- A dwell shorter than STABLE_CYCLES samples is never captured. If that digit was the expected one, the frame stalls until it is restarted by digit 0.
- Reset asserted mid-frame or while Valid=1: everything returns to reset values on that edge, and the pending frame is lost.

Test Plan:
- DIGITS=4, STABLE_CYCLES=4. Scan digits 0..3 with glyphs 1,2,A,F, DP off, 8 cycles each. Expect Value=16'hFA21, DPMask=0, BlankMask=0, Error=0, Valid=1 until Ack; Valid=0 one cycle after Ack.
- Same scan with DP lit on digit 2, digit 3 showing 1111111, and digit 1 showing 1111110 (unrecognised). Expect Value=16'h0A01, DPMask=4'b0100, BlankMask=4'b1000, Error=1.
- Digit 1 dwell of only 3 cycles, then digit 2. Expect no Valid. The following full scan 3,4,5,6 yields Value=16'h6543, Error=0.
- Out-of-order scan 0,2 (skip 1), then full scan 7,8,9,0. Expect only Value=16'h0987 reported. Overlap An=4'b1100 for 6 cycles inside a COLLECT frame gives Error=1 on that frame.
- Leave the first frame (16'h4321) unacknowledged and complete a second frame (16'h8765). Expect Overrun pulse of 1 cycle and Value still 16'h4321. Then assert Ack in the same cycle a third frame (16'hCDEF) completes: expect Value=16'hCDEF with Valid staying 1.
- Assert Reset for 1 cycle while Valid=1 and midway through digit 2 of a scan. Expect all outputs 0 next cycle; a following full scan reports correctly.
